// File: rtl/sw_sweep_capture.sv
// sw_sweep_capture: drives a nibble-replicated switch sweep {X,X,X} from X=F down to X=0,
// samples the LED response on the last cycle of each step into a 16-entry capture memory,
// and exposes the memory through a registered read port.
module sw_sweep_capture #(
    parameter int unsigned DWELL = 20
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    output logic [11:0] SW_OUT,
    input  logic [11:0] LED_IN,
    output logic        BUSY,
    output logic        DONE,
    input  logic [3:0]  RD_ADDR,
    output logic [11:0] RD_DATA
);

    // Last count value of a step; LED_IN is captured when the dwell counter reaches it.
    localparam logic [15:0] CntLast = 16'(DWELL - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  x_q, x_d;
    logic [15:0] cnt_q, cnt_d;
    logic [11:0] sw_out_q, sw_out_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [11:0] rd_data_q, rd_data_d;
    logic [11:0] mem_q [16];
    logic [11:0] mem_d [16];

    logic [3:0]  x_dec;
    logic        step_last;

    assign x_dec     = x_q - 4'd1;
    assign step_last = (cnt_q == CntLast);

    // Next-state logic for the sweep FSM, capture memory and read port.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        cnt_d    = cnt_q;
        sw_out_d = sw_out_q;
        busy_d   = busy_q;
        done_d   = done_q;
        mem_d    = mem_q;

        case (state_q)
            StIdle, StFin: begin
                // Memory is intentionally not cleared; each step overwrites its own entry.
                if (START) begin
                    state_d  = StRun;
                    x_d      = 4'hF;
                    cnt_d    = 16'd0;
                    sw_out_d = 12'hFFF;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                end
            end
            StRun: begin
                // START is ignored here; the sweep always runs to completion.
                if (!step_last) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    mem_d[x_q] = LED_IN;
                    cnt_d      = 16'd0;
                    if (x_q != 4'h0) begin
                        x_d      = x_dec;
                        sw_out_d = {x_dec, x_dec, x_dec};
                    end else begin
                        // X==0 is the final step, so X never wraps back to F.
                        state_d  = StFin;
                        sw_out_d = 12'h000;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = StIdle;
                x_d      = 4'hF;
                cnt_d    = 16'd0;
                sw_out_d = 12'h000;
                busy_d   = 1'b0;
                done_d   = 1'b0;
            end
        endcase

        // Read uses the pre-write memory contents, so a same-edge write returns old data.
        rd_data_d = mem_q[RD_ADDR];
    end

    // State, output and memory registers; reset aborts any sweep in progress.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StIdle;
            x_q       <= 4'hF;
            cnt_q     <= 16'd0;
            sw_out_q  <= 12'h000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= 12'h000;
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= 12'h000;
            end
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            cnt_q     <= cnt_d;
            sw_out_q  <= sw_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_data_q <= rd_data_d;
            mem_q     <= mem_d;
        end
    end

    assign SW_OUT  = sw_out_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign RD_DATA = rd_data_q;

endmodule

// File: tb/tb_sw_sweep_capture.sv
// Directed bench for sw_sweep_capture with DWELL=4 (64-cycle sweep).
module tb_sw_sweep_capture;

    localparam int unsigned Dwell = 4;
    localparam int NSteps = 16 * Dwell;

    // LED drive modes
    localparam int ModeInv   = 0;
    localparam int ModeLate  = 1;
    localparam int ModeConst = 2;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] sw_out;
    logic [11:0] led_in;
    logic        busy;
    logic        done;
    logic [3:0]  rd_addr;
    logic [11:0] rd_data;

    int n_checks = 0;
    int n_pass   = 0;

    sw_sweep_capture #(
        .DWELL(Dwell)
    ) u_dut (
        .CLK    (clk),
        .RST_N  (rst_n),
        .START  (start),
        .SW_OUT (sw_out),
        .LED_IN (led_in),
        .BUSY   (busy),
        .DONE   (done),
        .RD_ADDR(rd_addr),
        .RD_DATA(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Address set at one falling edge, data checked at the next one.
    task automatic read_check(input logic [3:0] addr, input logic [11:0] exp);
        @(negedge clk);
        rd_addr = addr;
        @(negedge clk);
        check_eq($sformatf("rd_data[%0h]", addr), {20'd0, rd_data}, {20'd0, exp});
    endtask

    // Runs one sweep from a START pulse. restart_at/abort_at < 0 disables the feature.
    // When rw_check is set, also checks same-edge write/read of mem[F] (old value prev_f).
    task automatic run_sweep(input int mode, input int restart_at, input int abort_at,
                             input logic rw_check, input logic [11:0] prev_f,
                             input logic [11:0] const_val);
        logic [3:0]  x;
        logic [11:0] rep;
        @(negedge clk);
        start = 1'b1;
        for (int n = 0; n < NSteps; n++) begin
            @(negedge clk);
            if (n == 0) start = 1'b0;
            if (n == restart_at) start = 1'b1;
            if (n == restart_at + 1) start = 1'b0;
            if (n == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_eq("abort_sw_out", {20'd0, sw_out}, 32'h0);
                check_eq("abort_busy", {31'd0, busy}, 32'h0);
                check_eq("abort_done", {31'd0, done}, 32'h0);
                check_eq("abort_rd_data", {20'd0, rd_data}, 32'h0);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            x   = 4'(15 - n / Dwell);
            rep = {x, x, x};
            check_eq($sformatf("sw_out@%0d", n), {20'd0, sw_out}, {20'd0, rep});
            check_eq($sformatf("busy@%0d", n), {31'd0, busy}, 32'h1);
            check_eq($sformatf("done@%0d", n), {31'd0, done}, 32'h0);
            case (mode)
                ModeInv:  led_in = ~rep;
                ModeLate: led_in = (n % Dwell == 0) ? 12'hBAD : (rep ^ 12'h5A5);
                default:  led_in = const_val;
            endcase
            if (rw_check) begin
                if (n == Dwell - 1) rd_addr = 4'hF;
                if (n == Dwell) check_eq("rw_same_edge_old", {20'd0, rd_data}, {20'd0, prev_f});
                if (n == Dwell + 1) check_eq("rw_after_new", {20'd0, rd_data}, {20'd0, const_val});
            end
        end
        @(negedge clk);
        check_eq("fin_done", {31'd0, done}, 32'h1);
        check_eq("fin_busy", {31'd0, busy}, 32'h0);
        check_eq("fin_sw_out", {20'd0, sw_out}, 32'h0);
        // No F step may be re-issued after the 0 step.
        repeat (3) @(negedge clk);
        check_eq("fin_no_wrap", {20'd0, sw_out}, 32'h0);
        check_eq("fin_done_hold", {31'd0, done}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] xv;
        rst_n   = 1'b0;
        start   = 1'b0;
        led_in  = 12'h000;
        rd_addr = 4'h0;

        // Reset held for three cycles
        repeat (3) @(negedge clk);
        check_eq("rst_sw_out", {20'd0, sw_out}, 32'h0);
        check_eq("rst_busy", {31'd0, busy}, 32'h0);
        check_eq("rst_done", {31'd0, done}, 32'h0);
        check_eq("rst_rd_data", {20'd0, rd_data}, 32'h0);
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) read_check(4'(a), 12'h000);
        check_eq("idle_busy", {31'd0, busy}, 32'h0);
        check_eq("idle_done", {31'd0, done}, 32'h0);

        // Inverse-of-stimulus sweep
        run_sweep(ModeInv, -1, -1, 1'b0, 12'h000, 12'h000);
        read_check(4'hF, 12'h000);
        read_check(4'h0, 12'hFFF);
        read_check(4'h5, 12'hAAA);
        for (int a = 0; a < 16; a++) begin
            xv = 4'(a);
            read_check(xv, ~{xv, xv, xv});
        end

        // LED changes on the 2nd cycle of each step; the late value must be captured
        run_sweep(ModeLate, -1, -1, 1'b0, 12'h000, 12'h000);
        for (int a = 0; a < 16; a++) begin
            xv = 4'(a);
            read_check(xv, {xv, xv, xv} ^ 12'h5A5);
        end

        // START re-pulsed mid-run must not disturb timing
        run_sweep(ModeInv, 10, -1, 1'b0, 12'h000, 12'h000);
        read_check(4'h3, 12'hCCC);

        // Second START from FIN with constant LED value; mem[F] held 000 before overwrite
        run_sweep(ModeConst, -1, -1, 1'b1, 12'h000, 12'h123);
        for (int a = 0; a < 16; a++) read_check(4'(a), 12'h123);

        // Reset at cycle 30 aborts; memory cleared; no DONE without a fresh START
        run_sweep(ModeInv, -1, 30, 1'b0, 12'h000, 12'h000);
        for (int a = 0; a < 16; a++) read_check(4'(a), 12'h000);
        repeat (NSteps + 6) @(negedge clk);
        check_eq("post_abort_done", {31'd0, done}, 32'h0);
        check_eq("post_abort_busy", {31'd0, busy}, 32'h0);
        check_eq("post_abort_sw_out", {20'd0, sw_out}, 32'h0);
        run_sweep(ModeConst, -1, -1, 1'b0, 12'h000, 12'h3C5);
        read_check(4'h7, 12'h3C5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
